// File: rtl/spi_ram_if.sv
// +-----------------------------------------------------------------------+
// | spi_ram_if : word-level link between the SPI slave and spi_ram_ctrl.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface spi_ram_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  // master = SPI slave side, slave = RAM controller side
  modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, cmd_err);
endinterface

`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
// +-----------------------------------------------------------------------+
// | spi_ram_ctrl : command decoder + single-port RAM behind the SPI slave. |
// | Optional macro RAM_AUTO_INC_EN: post-increment wr/rd addresses.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  spi_ram_if.slave   bus
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_READ_PEND = 2'd1;
  localparam logic [1:0] ST_TX_ACTIVE = 2'd2;

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [7:0]           mem [0:MEM_DEPTH-1];
  logic [7:0]           q;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 rd_addr_vld;
  logic                 err_q;
  logic                 rd_en;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 wr_addr_set;
  logic                 wr_en;
  logic                 rd_addr_set;
  logic                 rd_req;
  logic                 rd_start;
  logic                 err_d;

  assign cmd          = bus.din[9:8];
  assign payload_addr = bus.din[ADDR_SIZE-1:0];
  assign wr_addr_set  = bus.rx_valid && (cmd == CMD_WR_ADDR);
  assign wr_en        = bus.rx_valid && (cmd == CMD_WR_DATA);
  assign rd_addr_set  = bus.rx_valid && (cmd == CMD_RD_ADDR);
  assign rd_req       = bus.rx_valid && (cmd == CMD_RD_DATA);
  // A read already in flight cannot accept another RD_DATA; it is dropped as an error.
  assign rd_start     = rd_req && rd_addr_vld && (state != ST_READ_PEND);
  assign err_d        = rd_req && !rd_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (rd_start) next_state = ST_READ_PEND;
      ST_READ_PEND: next_state = ST_TX_ACTIVE;
      ST_TX_ACTIVE: begin
        if (rd_start)          next_state = ST_READ_PEND;
        else if (bus.rx_valid) next_state = ST_IDLE;
      end
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en        = (state == ST_READ_PEND);
    bus.tx_valid = (state == ST_TX_ACTIVE);
    bus.dout     = q;
    bus.cmd_err  = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_ptr      <= '0;
      rd_addr_vld <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d;
      if (wr_addr_set) begin
        wr_addr <= payload_addr;
      end
`ifdef RAM_AUTO_INC_EN
      else if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
      end
`endif
      // rd_ptr freezes the address of the accepted read so later address
      // updates during READ_PEND cannot disturb it.
      if (rd_start) begin
        rd_ptr <= rd_addr;
      end
      if (rd_addr_set) begin
        rd_addr     <= payload_addr;
        rd_addr_vld <= 1'b1;
      end else if (rd_start) begin
`ifdef RAM_AUTO_INC_EN
        rd_addr     <= rd_addr + 1'b1;
`else
        rd_addr_vld <= 1'b0;
`endif
      end
    end
  end

  // Write and registered read share an edge: a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.din[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (rd_en) begin
      q <= mem[rd_ptr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_spi_ram_ctrl : directed self-checking bench for spi_ram_ctrl.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_spi_ram_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_ram_if bus ();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one command for exactly one cycle; returns at the following negedge.
  task automatic send(input logic [1:0] c, input logic [7:0] d);
    bus.din      = {c, d};
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.din      = 10'h000;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%0b exp=0", bus.tx_valid); end
    checks++; if (bus.dout !== 8'h00)    begin errors++; $display("FAIL reset_dout got=%02h exp=00", bus.dout); end
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL reset_cmd_err got=%0b exp=0", bus.cmd_err); end
  endtask

  task automatic test_basic_read();
    apply_reset();
    send(2'b00, 8'h3C);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h3C);
    send(2'b11, 8'h00);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1_tx_valid got=%0b exp=0", bus.tx_valid); end
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL rd_cmd_err got=%0b exp=0", bus.cmd_err); end
    tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL rd_lat2_tx_valid got=%0b exp=1", bus.tx_valid); end
    checks++; if (bus.dout !== 8'hA5)    begin errors++; $display("FAIL rd_lat2_dout got=%02h exp=a5", bus.dout); end
    tick(); tick(); tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL rd_hold_tx_valid got=%0b exp=1", bus.tx_valid); end
    checks++; if (bus.dout !== 8'hA5)    begin errors++; $display("FAIL rd_hold_dout got=%02h exp=a5", bus.dout); end
    send(2'b00, 8'h00);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rd_release_tx_valid got=%0b exp=0", bus.tx_valid); end
    checks++; if (bus.dout !== 8'hA5)    begin errors++; $display("FAIL rd_release_dout got=%02h exp=a5", bus.dout); end
  endtask

  task automatic test_cmd_err();
    apply_reset();
    send(2'b11, 8'h00);
    checks++; if (bus.cmd_err !== 1'b1)  begin errors++; $display("FAIL err_noaddr_cmd_err got=%0b exp=1", bus.cmd_err); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL err_noaddr_tx_valid got=%0b exp=0", bus.tx_valid); end
    tick();
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL err_pulse_width got=%0b exp=0", bus.cmd_err); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL err_no_read_tx_valid got=%0b exp=0", bus.tx_valid); end
    send(2'b10, 8'h3C);
    send(2'b11, 8'h00);
    tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL err_good_read_tx_valid got=%0b exp=1", bus.tx_valid); end
    send(2'b11, 8'h00);
`ifdef RAM_AUTO_INC_EN
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL err_second_rd_cmd_err got=%0b exp=0", bus.cmd_err); end
`else
    checks++; if (bus.cmd_err !== 1'b1)  begin errors++; $display("FAIL err_second_rd_cmd_err got=%0b exp=1", bus.cmd_err); end
`endif
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL err_second_rd_tx_valid got=%0b exp=0", bus.tx_valid); end
    tick();
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL err_second_pulse_width got=%0b exp=0", bus.cmd_err); end
  endtask

  task automatic test_read_before_write();
    apply_reset();
    send(2'b00, 8'hFE);
    send(2'b01, 8'h11);
    send(2'b00, 8'hFF);
    send(2'b01, 8'h22);
    send(2'b00, 8'hFF);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    send(2'b01, 8'h77);
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL rbw_tx_valid got=%0b exp=1", bus.tx_valid); end
    checks++; if (bus.dout !== 8'h22)    begin errors++; $display("FAIL rbw_old_data got=%02h exp=22", bus.dout); end
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL rbw_cmd_err got=%0b exp=0", bus.cmd_err); end
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    tick();
    checks++; if (bus.dout !== 8'h77)    begin errors++; $display("FAIL rbw_reread got=%02h exp=77", bus.dout); end
    // RD_DATA while a read is pending is dropped and flagged.
    send(2'b10, 8'hFE);
    send(2'b11, 8'h00);
    send(2'b11, 8'h00);
    checks++; if (bus.cmd_err !== 1'b1)  begin errors++; $display("FAIL pend_rd_cmd_err got=%0b exp=1", bus.cmd_err); end
    checks++; if (bus.dout !== 8'h11)    begin errors++; $display("FAIL pend_rd_dout got=%02h exp=11", bus.dout); end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL pend_rd_tx_valid got=%0b exp=1", bus.tx_valid); end
  endtask

  task automatic test_back_to_back();
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    send(2'b10, 8'hFE);
    checks++; if (bus.dout !== 8'h77)    begin errors++; $display("FAIL b2b_first_dout got=%02h exp=77", bus.dout); end
    send(2'b11, 8'h00);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_tx_valid got=%0b exp=0", bus.tx_valid); end
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL b2b_cmd_err got=%0b exp=0", bus.cmd_err); end
    tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_tx_valid got=%0b exp=1", bus.tx_valid); end
    checks++; if (bus.dout !== 8'h11)    begin errors++; $display("FAIL b2b_second_dout got=%02h exp=11", bus.dout); end
  endtask

  task automatic test_addr_update();
    apply_reset();
    send(2'b00, 8'hFF);
    send(2'b01, 8'h01);
    send(2'b01, 8'h02);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    tick();
`ifdef RAM_AUTO_INC_EN
    checks++; if (bus.dout !== 8'h01)    begin errors++; $display("FAIL inc_first_dout got=%02h exp=01", bus.dout); end
    send(2'b11, 8'h00);
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL inc_cmd_err got=%0b exp=0", bus.cmd_err); end
    tick();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL inc_wrap_tx_valid got=%0b exp=1", bus.tx_valid); end
    checks++; if (bus.dout !== 8'h02)    begin errors++; $display("FAIL inc_wrap_dout got=%02h exp=02", bus.dout); end
`else
    checks++; if (bus.dout !== 8'h02)    begin errors++; $display("FAIL noinc_overwrite_dout got=%02h exp=02", bus.dout); end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL noinc_tx_valid got=%0b exp=1", bus.tx_valid); end
`endif
  endtask

  task automatic test_reset_mid_read();
    send(2'b10, 8'hFE);
    send(2'b11, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid got=%0b exp=0", bus.tx_valid); end
    checks++; if (bus.dout !== 8'h00)    begin errors++; $display("FAIL midrst_dout got=%02h exp=00", bus.dout); end
    checks++; if (bus.cmd_err !== 1'b0)  begin errors++; $display("FAIL midrst_cmd_err got=%0b exp=0", bus.cmd_err); end
    rst_n = 1'b1;
    send(2'b11, 8'h00);
    checks++; if (bus.cmd_err !== 1'b1)  begin errors++; $display("FAIL midrst_vld_cleared got=%0b exp=1", bus.cmd_err); end
    tick();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_tx got=%0b exp=0", bus.tx_valid); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.din      = 10'h000;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_read();
    test_cmd_err();
    test_read_before_write();
    test_back_to_back();
    test_addr_update();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port RAM controller that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid words, decodes the 2-bit command, and performs address latch, write and read operations on an internal synchronous RAM.
- Returns read data to the SPI slave on tx_data/tx_valid for serialisation on MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit RAM words.
- ADDR_SIZE, 8, address width; MEM_DEPTH must equal 2**ADDR_SIZE.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  10  command word from SPI slave; din[9:8] = command, din[7:0] = payload.
- rx_valid  input  1  din is valid this cycle; single-cycle pulse.
- dout  output  8  read data to SPI slave (its tx_data).
- tx_valid  output  1  dout valid; held until released (see Behaviour).
- cmd_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - dout=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, rd_addr_vld=0, state=IDLE.
  - RAM contents are not reset and are undefined.
  - Reset mid-read aborts the read; tx_valid is 0 on the following cycle.
- Commands, decoded only when rx_valid=1; din ignored otherwise:
  - 00 WR_ADDR: wr_addr <= din[7:0].
  - 01 WR_DATA: mem[wr_addr] <= din[7:0]. Write commits at the same edge that samples rx_valid.
  - 10 RD_ADDR: rd_addr <= din[7:0]; rd_addr_vld <= 1.
  - 11 RD_DATA: if rd_addr_vld=1, start a read; rd_addr_vld <= 0. If rd_addr_vld=0, pulse cmd_err for 1 cycle; no read, no tx_valid. din[7:0] is don't-care.
- State machine: IDLE, READ_PEND, TX_ACTIVE.
  - IDLE -> READ_PEND on an accepted RD_DATA (rx_valid at edge N).
  - READ_PEND (cycle N+1): registered RAM read of mem[rd_addr] into q. Unconditionally -> TX_ACTIVE.
  - TX_ACTIVE: dout=q and tx_valid=1 from edge N+2, so latency = 2 clk from rx_valid to tx_valid. dout stays stable while tx_valid=1.
  - TX_ACTIVE -> IDLE on the next rx_valid of any command. tx_valid=0 and dout holds its last value from the following edge; that command is executed in the same cycle.
  - An RD_DATA arriving in TX_ACTIVE with rd_addr_vld=1 goes directly TX_ACTIVE -> READ_PEND. tx_valid drops for 1 cycle, then reasserts with the new data.
- Simultaneous events:
  - rx_valid during READ_PEND: commands 00/01/10 execute normally and the pending read still completes. An RD_DATA in READ_PEND is dropped and pulses cmd_err.
  - WR_DATA to rd_addr during READ_PEND: read-before-write; q returns the old contents.
- Address width: addresses are ADDR_SIZE bits; increments wrap modulo MEM_DEPTH (255+1 -> 0).
- cmd_err: registered, asserted the cycle after the offending rx_valid, high for exactly 1 cycle.

Optional Feature:
- Macro: RAM_AUTO_INC_EN.
- Defined:
  - After each WR_DATA, wr_addr <= wr_addr+1 (wrapping).
  - After each accepted RD_DATA, rd_addr <= rd_addr+1 (wrapping) and rd_addr_vld stays 1, so consecutive RD_DATA commands stream sequential words without re-sending RD_ADDR.
- Not defined:
  - Addresses change only via WR_ADDR/RD_ADDR.
  - rd_addr_vld clears after each RD_DATA.

Test Plan:
- Reset, then WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA -> tx_valid=1 and dout=0xA5 exactly 2 clk after the RD_DATA rx_valid; tx_valid held until the next rx_valid.
- Reset, then RD_DATA without a prior RD_ADDR -> cmd_err high for 1 cycle, tx_valid stays 0; a second RD_DATA after one successful read also flags cmd_err (macro undefined).
- Fill 0xFE=0x11 and 0xFF=0x22; RD_ADDR 0xFF then RD_DATA; issue WR_DATA 0x77 to 0xFF during READ_PEND -> dout=0x22 (old data); a re-read returns 0x77.
- With RAM_AUTO_INC_EN: WR_ADDR 0xFF, WR_DATA 0x01, WR_DATA 0x02 -> mem[0xFF]=0x01, mem[0x00]=0x02; RD_ADDR 0xFF, RD_DATA, RD_DATA -> dout 0x01 then 0x02, no cmd_err.
- Assert rst_n=0 in READ_PEND -> next cycle tx_valid=0, dout=0, cmd_err=0, rd_addr_vld=0; a following RD_DATA flags cmd_err.
